// File: rtl/glb_pkg.sv
// rtl/glb_pkg.sv - shared types, default sizes and helpers for the global-buffer writer
package glb_pkg;

    typedef enum logic [1:0] {
        ST_CLR  = 2'd0,
        ST_IDLE = 2'd1,
        ST_LOAD = 2'd2
    } glb_state_e;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_COL    = 10;
    localparam int DEF_NUM_ROW    = 4;

    localparam int COL_W = (DEF_NUM_COL > 1) ? $clog2(DEF_NUM_COL) : 1;
    localparam int ROW_W = (DEF_NUM_ROW > 1) ? $clog2(DEF_NUM_ROW) : 1;

    // Effective kernel rows: K=0 behaves as 1, K beyond the array saturates.
    function automatic logic [7:0] clamp_k(input logic [7:0] k, input int num_row);
        logic [7:0] nr;
        nr = 8'(num_row);
        if (k == 8'd0)
            return 8'd1;
        else if (k > nr)
            return nr;
        else
            return k;
    endfunction

endpackage

// File: rtl/glb_addr_gen.sv
// rtl/glb_addr_gen.sv - column/row wrap counter with kernel-size clamp and pass-done flag
module glb_addr_gen
    import glb_pkg::*;
#(
    parameter int  NUM_COL = DEF_NUM_COL,
    parameter int  NUM_ROW = DEF_NUM_ROW,
    localparam int CW      = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
    localparam int RW      = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clear_i,
    input  logic          latch_k_i,
    input  logic          adv_i,
    input  logic [7:0]    kernel_size_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          done_o
);

    localparam logic [CW-1:0] COL_LAST = CW'(NUM_COL - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    keff_q, keff_d;
    logic [7:0]    keff;
    logic          col_wrap;
    logic          row_last;

    // The first word of a pass is written in the same cycle K is latched.
    assign keff     = latch_k_i ? clamp_k(kernel_size_i, NUM_ROW) : keff_q;
    assign col_wrap = (col_q == COL_LAST);
    assign row_last = (8'(row_q) == (keff - 8'd1));

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        keff_d = keff;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (adv_i) begin
            col_d = col_wrap ? '0 : col_q + 1'b1;
            if (col_wrap)
                row_d = row_last ? '0 : row_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            col_q  <= '0;
            row_q  <= '0;
            keff_q <= 8'd1;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            keff_q <= keff_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign done_o = adv_i & col_wrap & row_last;

endmodule

// File: rtl/glb_buf.sv
// rtl/glb_buf.sv - global-buffer writer: clear sequence, stream load to PE array, start trigger
module glb_buf
    import glb_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  NUM_COL    = DEF_NUM_COL,
    parameter int  NUM_ROW    = DEF_NUM_ROW,
    localparam int CW         = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
    localparam int RW         = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1
) (
    input  logic                  bus_clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [7:0]            kernel_size,
    output logic                  rstn_busy,
    output logic                  bus_wen,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic [CW-1:0]         bus_col,
    output logic [RW-1:0]         bus_row,
    output logic                  bus_clr,
    output logic                  bus_start,
    output logic                  bus_done
);

    localparam logic [CW-1:0] CLR_LAST = CW'(NUM_COL - 1);

    glb_state_e            state_q, state_d;
    logic [CW-1:0]         clr_cnt_q, clr_cnt_d;
    logic                  start_q;
    logic                  accept;
    logic                  start_pulse;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  done;

    logic                  clr_q, clr_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  bstart_q, bstart_d;
    logic                  done_q, done_d;

    assign accept      = (state_q != ST_CLR) && flush;
    assign start_pulse = (state_q == ST_IDLE) && !flush && start && !start_q;

    glb_addr_gen #(
        .NUM_COL (NUM_COL),
        .NUM_ROW (NUM_ROW)
    ) u_addr_gen (
        .clk_i         (bus_clk),
        .rst_n_i       (rstn),
        .clear_i       ((state_q == ST_CLR) || ((state_q == ST_LOAD) && !flush)),
        .latch_k_i     ((state_q == ST_IDLE) && flush),
        .adv_i         (accept),
        .kernel_size_i (kernel_size),
        .col_o         (col),
        .row_o         (row),
        .done_o        (done)
    );

    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_CLR;
            clr_cnt_q <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            start_q   <= start;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = '0;
        case (state_q)
            ST_CLR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST)
                    state_d = ST_IDLE;
            end
            ST_IDLE: if (flush) state_d = ST_LOAD;
            ST_LOAD: if (!flush) state_d = ST_IDLE;
            default: state_d = ST_CLR;
        endcase
    end

    always_comb begin
        clr_d    = (state_d == ST_CLR);
        wen_d    = accept;
        data_d   = accept ? data_in : data_q;
        col_d    = accept ? col : col_q;
        row_d    = accept ? row : row_q;
        done_d   = done;
        bstart_d = start_pulse;
    end

    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            clr_q    <= 1'b1;
            wen_q    <= 1'b0;
            data_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            done_q   <= 1'b0;
            bstart_q <= 1'b0;
        end else begin
            clr_q    <= clr_d;
            wen_q    <= wen_d;
            data_q   <= data_d;
            col_q    <= col_d;
            row_q    <= row_d;
            done_q   <= done_d;
            bstart_q <= bstart_d;
        end
    end

    assign rstn_busy = clr_q;
    assign bus_clr   = clr_q;
    assign bus_wen   = wen_q;
    assign bus_data  = data_q;
    assign bus_col   = col_q;
    assign bus_row   = row_q;
    assign bus_done  = done_q;
    assign bus_start = bstart_q;

endmodule

// File: tb/tb_glb_buf.sv
// tb/tb_glb_buf.sv - table-driven self-checking bench for glb_buf
module tb_glb_buf;
    import glb_pkg::*;

    typedef struct {
        logic        flush;
        logic        start;
        logic [15:0] data;
        logic [7:0]  k;
        logic        wen;
        logic [15:0] bdata;
        logic [3:0]  col;
        logic [1:0]  row;
        logic        done;
        logic        bstart;
    } vec_t;

    logic        bus_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic [7:0]  kernel_size = 8'd3;
    logic        rstn_busy;
    logic        bus_wen;
    logic [15:0] bus_data;
    logic [3:0]  bus_col;
    logic [1:0]  bus_row;
    logic        bus_clr;
    logic        bus_start;
    logic        bus_done;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 bus_clk = ~bus_clk;

    glb_buf dut (
        .bus_clk     (bus_clk),
        .rstn        (rstn),
        .flush       (flush),
        .start       (start),
        .data_in     (data_in),
        .kernel_size (kernel_size),
        .rstn_busy   (rstn_busy),
        .bus_wen     (bus_wen),
        .bus_data    (bus_data),
        .bus_col     (bus_col),
        .bus_row     (bus_row),
        .bus_clr     (bus_clr),
        .bus_start   (bus_start),
        .bus_done    (bus_done)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic f, input logic s, input logic [15:0] d, input logic [7:0] k,
                       input logic w, input logic [15:0] bd, input int c, input int r,
                       input logic dn, input logic bs);
        vec_t v;
        v.flush = f; v.start = s; v.data = d; v.k = k;
        v.wen = w; v.bdata = bd; v.col = 4'(c); v.row = 2'(r); v.done = dn; v.bstart = bs;
        vecs.push_back(v);
    endtask

    // Words n=first..last streamed with kernel size k; rows wrap at kwrap, done on pass end.
    task automatic add_ramp(input int first, input int last, input logic [7:0] k, input int kwrap);
        for (int n = first; n <= last; n++)
            add(1'b1, 1'b0, 16'(n), k, 1'b1, 16'(n), (n - first) % 10, ((n - first) / 10) % kwrap,
                (((n - first) % (10 * kwrap)) == (10 * kwrap - 1)), 1'b0);
    endtask

    task automatic add_idle(input logic s, input logic bs);
        add(1'b0, s, 16'h0, 8'd3, 1'b0, 16'h0, 0, 0, 1'b0, bs);
    endtask

    // Called at a negedge; each vector's outputs are checked one cycle after it is driven.
    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            flush = vecs[i].flush;
            start = vecs[i].start;
            data_in = vecs[i].data;
            kernel_size = vecs[i].k;
            @(posedge bus_clk);
            @(negedge bus_clk);
            chk({tag, ".wen"}, i, 32'(bus_wen), 32'(vecs[i].wen));
            chk({tag, ".done"}, i, 32'(bus_done), 32'(vecs[i].done));
            chk({tag, ".start"}, i, 32'(bus_start), 32'(vecs[i].bstart));
            if (vecs[i].wen) begin
                chk({tag, ".data"}, i, 32'(bus_data), 32'(vecs[i].bdata));
                chk({tag, ".col"}, i, 32'(bus_col), 32'(vecs[i].col));
                chk({tag, ".row"}, i, 32'(bus_row), 32'(vecs[i].row));
            end
        end
        vecs.delete();
    endtask

    // Called at a negedge; asserts reset, checks it acts at once, then walks the clear sequence.
    task automatic do_reset(input string tag, input logic hold_flush);
        rstn = 1'b0;
        flush = hold_flush;
        start = 1'b0;
        kernel_size = 8'd3;
        #1;
        chk({tag, ".rst_busy"}, 0, 32'(rstn_busy), 32'd1);
        chk({tag, ".rst_clr"}, 0, 32'(bus_clr), 32'd1);
        chk({tag, ".rst_outs"}, 0, {bus_wen, bus_done, bus_start, bus_data, bus_col, bus_row}, 32'd0);
        repeat (5) @(negedge bus_clk);
        chk({tag, ".rst_busy"}, 1, 32'(rstn_busy), 32'd1);
        rstn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge bus_clk);
            chk({tag, ".clr_busy"}, i, 32'(rstn_busy), (i < 10) ? 32'd1 : 32'd0);
            chk({tag, ".clr_clr"}, i, 32'(bus_clr), (i < 10) ? 32'd1 : 32'd0);
            chk({tag, ".clr_wen"}, i, 32'(bus_wen), 32'd0);
        end
    endtask

    initial begin
        @(negedge bus_clk);
        do_reset("reset", 1'b1);

        // Ramp K=3 with flush already high; kernel_size change mid-load must be ignored.
        add_ramp(0, 34, 8'd3, 3);
        for (int n = 35; n <= 59; n++)
            add(1'b1, 1'b0, 16'(n), 8'd1, 1'b1, 16'(n), n % 10, (n / 10) % 3,
                (n == 59), 1'b0);
        add_idle(1'b0, 1'b0);
        run_vecs("ramp");

        // Drop flush after word 14 of a pass; next word restarts at (0,0).
        add_ramp(100, 114, 8'd3, 3);
        add_idle(1'b0, 1'b0);
        add(1'b1, 1'b0, 16'hbeef, 8'd3, 1'b1, 16'hbeef, 0, 0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 16'hcafe, 8'd3, 1'b1, 16'hcafe, 1, 0, 1'b0, 1'b0);
        add_idle(1'b0, 1'b0);
        run_vecs("drop");

        // Start pulses: one-cycle, five-cycle level, and during load.
        add_idle(1'b1, 1'b1);
        add_idle(1'b0, 1'b0);
        add_idle(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) add_idle(1'b1, 1'b0);
        add_idle(1'b0, 1'b0);
        add(1'b1, 1'b0, 16'h11, 8'd3, 1'b1, 16'h11, 0, 0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 16'h12, 8'd3, 1'b1, 16'h12, 1, 0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 16'h13, 8'd3, 1'b1, 16'h13, 2, 0, 1'b0, 1'b0);
        add_idle(1'b0, 1'b0);
        add_idle(1'b0, 1'b0);
        run_vecs("start");

        // Clamps: K=0 behaves as one row; K=9 saturates at four rows.
        add_ramp(200, 219, 8'd0, 1);
        add_idle(1'b0, 1'b0);
        add_ramp(300, 339, 8'd9, 4);
        add(1'b1, 1'b0, 16'd340, 8'd9, 1'b1, 16'd340, 0, 0, 1'b0, 1'b0);
        add_idle(1'b0, 1'b0);
        run_vecs("clamp");

        // Reset in the middle of a load pass.
        add_ramp(400, 407, 8'd3, 3);
        run_vecs("midload");
        chk("midload.pre_wen", 0, 32'(bus_wen), 32'd1);
        do_reset("midreset", 1'b1);
        add_ramp(500, 502, 8'd3, 3);
        add_idle(1'b0, 1'b0);
        run_vecs("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/glb_buf.md
# glb_buf

Global-buffer writer for the convolution accelerator. It accepts one data word per bus clock from the host-side stream and distributes it over the universal bus (`UniV_BUS_CTRL_IF`) to the PE array of `NUM_ROW` × `NUM_COL` elements, addressing columns round-robin and rows modulo the kernel size. It also runs a post-reset clear sequence, flagged by `rstn_busy`, and issues the compute-start trigger to the PE set.

## Interface

- `DATA_WIDTH`, 16, word width.
- `NUM_COL`, 10, PE columns; equals the bus-clock to PE-clock ratio.
- `NUM_ROW`, 4, PE rows.
- `bus_clk` in 1: the single clock; all logic rises on it.
- `rstn` in 1: reset, asynchronous, active-low.
- `flush` in 1: load-mode request; stream words while high.
- `start` in 1: compute-start request.
- `data_in` in `DATA_WIDTH`: stream word, sampled when accepted.
- `kernel_size` in 8: K, the number of kernel rows used.
- `rstn_busy` out 1: clear sequence in progress; `data_in` is not accepted.
- `UniV_BUS_CTRL_IF` is the BUS_CTRL interface, master side. It carries these registered outputs:
  - `bus_wen` (1): write enable.
  - `bus_data` (`DATA_WIDTH`): write data.
  - `bus_col` ($clog2(`NUM_COL`)): column address.
  - `bus_row` ($clog2(`NUM_ROW`)): row address.
  - `bus_clr` (1): clear broadcast.
  - `bus_start` (1): compute-start pulse.
  - `bus_done` (1): one-cycle pulse at end of a load pass.

## Operation

- FSM states: CLR, IDLE, LOAD.
- CLR
  - Entered asynchronously while `rstn`=0 and held there.
  - After release, stays for exactly `NUM_COL` cycles, then goes to IDLE.
  - `rstn_busy`=1 and `bus_clr`=1 throughout CLR.
- IDLE
  - `flush`=1 → LOAD; the word on `data_in` is accepted in this same cycle.
  - `start`=1 with `flush`=0 → one-cycle `bus_start` pulse; FSM stays in IDLE.
- LOAD
  - Each cycle with `flush`=1, accept `data_in` and write it to (`row_cnt`, `col_cnt`).
  - `col_cnt` increments, wrapping at `NUM_COL`−1 → 0.
  - On a column wrap, `row_cnt` increments, wrapping at Keff−1 → 0.
  - Keff = K clamped to 1..`NUM_ROW`, so K=0 → 1 and K>`NUM_ROW` → `NUM_ROW`.
  - Keff is latched on entry to LOAD; `kernel_size` changes during LOAD are ignored.
  - The write at (Keff−1, `NUM_COL`−1) completes a pass: `bus_done` pulses with that write, and the counters wrap and continue.
  - `flush`=0 → IDLE with counters cleared, so a partial pass is abandoned.
  - `start` is ignored in LOAD.
- Priority: reset > CLR > `flush` > `start`.
- Reset values:
  - State CLR, `rstn_busy`=1, `bus_clr`=1.
  - All other outputs 0; counters 0.

## Timing

- Write latency is 1 cycle: a word accepted on edge n appears on `bus_data`/`bus_wen`/`bus_col`/`bus_row` after edge n+1 and is held for one cycle.
- `bus_wen` is 0 in every cycle without an accepted word.
- `rstn_busy` falls on the `NUM_COL`-th rising edge after `rstn` rises.
- A `flush` held high through CLR is first accepted in the cycle after `rstn_busy` falls.
- `bus_start` rises the cycle after `start` is sampled high in IDLE and lasts 1 cycle; a level-held `start` produces exactly one pulse until `start` returns to 0.
- Reset asserted mid-LOAD immediately zeroes the outputs and restarts the CLR sequence.

## Structure

- Shared package `glb_pkg` holds:
  - the state enum `glb_state_e`;
  - `DATA_WIDTH`/`NUM_COL`/`NUM_ROW` defaults;
  - `COL_W`/`ROW_W` width localparams.
- The BUS_CTRL interface definition is shared with `glb_PE_SET`.
- One natural sub-module, `glb_addr_gen`: the column/row wrap counter with Keff clamp and done generation.

## Test plan

- Reset with `NUM_COL`=10: pulse `rstn` low 50 ns → `rstn_busy`=1 during reset and for 10 cycles after release; `bus_clr`=1 over the same span; `bus_wen`=0.
- Flush ramp, K=3: hold `flush`, drive `data_in` = 0,1,2,… after `rstn_busy` falls → word n appears one cycle later with `bus_col`=n%10 and `bus_row`=(n/10)%3.
  - `bus_done` pulses with words 29, 59, …
- Flush drop: lower `flush` after word 14, then re-raise it → the next word goes to row 0, col 0.
- Start: 1-cycle and 5-cycle `start` in IDLE → exactly one 1-cycle `bus_start` each; `start` during LOAD → no pulse.
- Clamps:
  - K=0 → `bus_row` stays 0 and `bus_done` pulses every 10 words.
  - K=9 → rows wrap at 3 and `bus_done` pulses every 40 words.
- Reset mid-LOAD at word 7 → outputs zero immediately; the CLR sequence repeats; counters restart at (0,0).
